// File: rtl/mips_defs.sv
// Shared definitions for the MIPS pipeline front end: reset vector, bubble word
// and the IF/ID register layout.
package mips_defs;

   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
   localparam logic [31:0] NOP_WORD          = 32'h0;
   localparam int          IM_ADDR_W_DEFAULT = 10;

   typedef enum logic [1:0] {
      PC_SEQ,
      PC_HOLD,
      PC_REDIRECT
   } pcSel_t;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        valid;
      logic        adel;
   } ifId_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: Reset or Flush inserts a bubble, Stall freezes it.
import mips_defs::*;

module if_id_reg (
   input  logic  Clk,
   input  logic  Reset,
   input  logic  Flush,
   input  logic  Stall,
   input  ifId_t d,
   output ifId_t q
);

   // Flush wins over Stall so a squashed instruction never lingers in D.
   always_ff @(posedge Clk) begin
      if (Reset || Flush) begin
         q <= '{ir: NOP_WORD, pc: 32'h0, pc4: 32'h0, valid: 1'b0, adel: 1'b0};
      end else if (!Stall) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, IM addressing and
// the IF/ID register feeding the decode stage.
import mips_defs::*;

module fetch_unit #(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          IM_ADDR_W = IM_ADDR_W_DEFAULT
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Stall,
   input  logic                 Redirect,
   input  logic [31:0]          RedirectPC,
   input  logic                 Flush,
   output logic [IM_ADDR_W-1:0] ImAddr,
   input  logic [31:0]          ImInstr,
   output logic [31:0]          PC_F,
   output logic [31:0]          IR_D,
   output logic [31:0]          PC_D,
   output logic [31:0]          PC4_D,
   output logic                 Valid_D,
   output logic                 AdEL_D
);

   logic [31:0] imOffset;
   logic [31:0] pcPlus4;
   logic        inRange;
   pcSel_t      pcSel;
   ifId_t       ifIdNext;
   ifId_t       ifIdQ;

   // Offset wraps, so PCs below the window land in the high half and fail inRange.
   assign imOffset = PC_F - RESET_PC;
   assign ImAddr   = imOffset[IM_ADDR_W+1:2];
   assign inRange  = (imOffset[31:IM_ADDR_W+2] == '0);
   assign pcPlus4  = PC_F + 32'd4;

   // A stalled redirect is dropped; D re-asserts it once the stall clears.
   always_comb begin
      pcSel = PC_SEQ;
      if (Stall && !Flush) begin
         pcSel = PC_HOLD;
      end else if (Redirect) begin
         pcSel = PC_REDIRECT;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         PC_F <= RESET_PC;
      end else begin
         case (pcSel)
            PC_HOLD:     PC_F <= PC_F;
            PC_REDIRECT: PC_F <= {RedirectPC[31:2], 2'b00};
            default:     PC_F <= pcPlus4;
         endcase
      end
   end

   always_comb begin
      ifIdNext.ir    = inRange ? ImInstr : NOP_WORD;
      ifIdNext.pc    = PC_F;
      ifIdNext.pc4   = pcPlus4;
      ifIdNext.valid = 1'b1;
      ifIdNext.adel  = !inRange;
   end

   if_id_reg ifIdReg (
      .Clk   (Clk),
      .Reset (Reset),
      .Flush (Flush),
      .Stall (Stall),
      .d     (ifIdNext),
      .q     (ifIdQ)
   );

   assign IR_D    = ifIdQ.ir;
   assign PC_D    = ifIdQ.pc;
   assign PC4_D   = ifIdQ.pc4;
   assign Valid_D = ifIdQ.valid;
   assign AdEL_D  = ifIdQ.adel;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a behavioural model of the fetch stage.
module tb_fetch_unit;

   localparam logic [31:0] BASE = 32'h0000_3000;

   logic        Clk;
   logic        Reset;
   logic        Stall;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        Flush;
   logic [9:0]  ImAddr;
   logic [31:0] ImInstr;
   logic [31:0] PC_F;
   logic [31:0] IR_D;
   logic [31:0] PC_D;
   logic [31:0] PC4_D;
   logic        Valid_D;
   logic        AdEL_D;

   logic [31:0] imMem [0:1023];

   int total = 0;
   int bad   = 0;

   // Reference state of the fetch stage as seen after each clock edge.
   logic [31:0] mPc, mIr, mPcD, mPc4D;
   logic        mValid, mAdel;

   fetch_unit dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Stall      (Stall),
      .Redirect   (Redirect),
      .RedirectPC (RedirectPC),
      .Flush      (Flush),
      .ImAddr     (ImAddr),
      .ImInstr    (ImInstr),
      .PC_F       (PC_F),
      .IR_D       (IR_D),
      .PC_D       (PC_D),
      .PC4_D      (PC4_D),
      .Valid_D    (Valid_D),
      .AdEL_D     (AdEL_D)
   );

   assign ImInstr = imMem[ImAddr];

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic logic [9:0] expImAddr(input logic [31:0] pc);
      logic [31:0] ofs;
      ofs = (pc - BASE) / 4;
      return ofs[9:0];
   endfunction

   // Drive one cycle of inputs, advance the model, then sample 1 time unit past the edge.
   task automatic applyStimulus(input logic r, input logic s, input logic red,
                                input logic [31:0] rpc, input logic f);
      logic [31:0] ofs;
      logic [31:0] fetched;
      logic        inWin;
      Reset = r; Stall = s; Redirect = red; RedirectPC = rpc; Flush = f;
      if (r) begin
         mPc = BASE; mIr = 0; mPcD = 0; mPc4D = 0; mValid = 0; mAdel = 0;
      end else begin
         ofs   = mPc - BASE;
         inWin = (ofs < 32'd4096);
         fetched = inWin ? imMem[ofs / 4] : 32'h0;
         if (f) begin
            mIr = 0; mPcD = 0; mPc4D = 0; mValid = 0; mAdel = 0;
         end else if (!s) begin
            mIr = fetched; mPcD = mPc; mPc4D = mPc + 4; mValid = 1; mAdel = !inWin;
         end
         if (s && !f) mPc = mPc;
         else if (red) mPc = rpc & 32'hFFFF_FFFC;
         else mPc = mPc + 4;
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset;
      applyStimulus(1, 0, 0, 32'h0, 0);
      total++; if (PC_F !== 32'h3000) begin bad++; $display("[TB] FAIL reset_pc got=%h want=%h", PC_F, 32'h3000); end
      total++; if (IR_D !== 32'h0) begin bad++; $display("[TB] FAIL reset_ir got=%h want=0", IR_D); end
      total++; if ({Valid_D, AdEL_D} !== 2'b00) begin bad++; $display("[TB] FAIL reset_flags got=%b want=00", {Valid_D, AdEL_D}); end
      total++; if ({PC_D, PC4_D} !== 64'h0) begin bad++; $display("[TB] FAIL reset_pcd got=%h/%h want=0/0", PC_D, PC4_D); end
      total++; if (ImAddr !== 10'd0) begin bad++; $display("[TB] FAIL reset_imaddr got=%0d want=0", ImAddr); end
   endtask

   task automatic test_freerun;
      logic [31:0] words [3];
      words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 32'h0, 0);
         total++; if (PC_D !== BASE + 4 * i) begin bad++; $display("[TB] FAIL run_pcd%0d got=%h want=%h", i, PC_D, BASE + 4 * i); end
         total++; if (IR_D !== words[i]) begin bad++; $display("[TB] FAIL run_ir%0d got=%h want=%h", i, IR_D, words[i]); end
         total++; if (PC4_D !== BASE + 4 * i + 4) begin bad++; $display("[TB] FAIL run_pc4d%0d got=%h want=%h", i, PC4_D, BASE + 4 * i + 4); end
         total++; if (Valid_D !== 1'b1) begin bad++; $display("[TB] FAIL run_valid%0d got=%b want=1", i, Valid_D); end
         total++; if (ImAddr !== 10'(i + 1)) begin bad++; $display("[TB] FAIL run_imaddr%0d got=%0d want=%0d", i, ImAddr, i + 1); end
      end
   endtask

   task automatic test_stall;
      logic [31:0] heldPc, heldIr, heldPcD;
      heldPc = mPc; heldIr = mIr; heldPcD = mPcD;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 1, 0, 32'h0, 0);
         total++; if (PC_F !== heldPc) begin bad++; $display("[TB] FAIL stall_pc%0d got=%h want=%h", i, PC_F, heldPc); end
         total++; if (IR_D !== heldIr) begin bad++; $display("[TB] FAIL stall_ir%0d got=%h want=%h", i, IR_D, heldIr); end
         total++; if (PC_D !== heldPcD) begin bad++; $display("[TB] FAIL stall_pcd%0d got=%h want=%h", i, PC_D, heldPcD); end
      end
      applyStimulus(0, 0, 0, 32'h0, 0);
      total++; if (PC_F !== heldPc + 4) begin bad++; $display("[TB] FAIL stall_resume got=%h want=%h", PC_F, heldPc + 4); end
      total++; if (PC_D !== heldPc) begin bad++; $display("[TB] FAIL stall_resume_pcd got=%h want=%h", PC_D, heldPc); end
   endtask

   task automatic test_redirect;
      total++; if (PC_F !== 32'h3010) begin bad++; $display("[TB] FAIL redir_start got=%h want=%h", PC_F, 32'h3010); end
      applyStimulus(0, 0, 1, 32'h3043, 0);
      total++; if (PC_F !== 32'h3040) begin bad++; $display("[TB] FAIL redir_pc got=%h want=%h", PC_F, 32'h3040); end
      total++; if (PC_D !== 32'h3010) begin bad++; $display("[TB] FAIL redir_slot_pcd got=%h want=%h", PC_D, 32'h3010); end
      total++; if (IR_D !== imMem[4]) begin bad++; $display("[TB] FAIL redir_slot_ir got=%h want=%h", IR_D, imMem[4]); end
      total++; if (Valid_D !== 1'b1) begin bad++; $display("[TB] FAIL redir_slot_valid got=%b want=1", Valid_D); end
      total++; if (ImAddr !== 10'h10) begin bad++; $display("[TB] FAIL redir_imaddr got=%h want=%h", ImAddr, 10'h10); end
   endtask

   task automatic test_redirect_stall;
      logic [31:0] heldPc;
      heldPc = mPc;
      applyStimulus(0, 1, 1, 32'h3100, 0);
      total++; if (PC_F !== heldPc) begin bad++; $display("[TB] FAIL redstall_hold got=%h want=%h", PC_F, heldPc); end
      applyStimulus(0, 0, 1, 32'h3100, 0);
      total++; if (PC_F !== 32'h3100) begin bad++; $display("[TB] FAIL redstall_take got=%h want=%h", PC_F, 32'h3100); end
   endtask

   task automatic test_flush_stall;
      logic [31:0] startPc;
      startPc = mPc;
      applyStimulus(0, 1, 0, 32'h0, 1);
      total++; if (IR_D !== 32'h0) begin bad++; $display("[TB] FAIL flush_ir got=%h want=0", IR_D); end
      total++; if (Valid_D !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid got=%b want=0", Valid_D); end
      total++; if (PC_F !== startPc + 4) begin bad++; $display("[TB] FAIL flush_pc got=%h want=%h", PC_F, startPc + 4); end
   endtask

   task automatic test_out_of_window;
      applyStimulus(0, 0, 1, 32'h4000, 0);
      applyStimulus(0, 0, 1, 32'h2FFC, 0);
      total++; if (IR_D !== 32'h0) begin bad++; $display("[TB] FAIL oow_ir got=%h want=0", IR_D); end
      total++; if ({Valid_D, AdEL_D} !== 2'b11) begin bad++; $display("[TB] FAIL oow_flags got=%b want=11", {Valid_D, AdEL_D}); end
      total++; if (PC_D !== 32'h4000) begin bad++; $display("[TB] FAIL oow_pcd got=%h want=%h", PC_D, 32'h4000); end
      applyStimulus(0, 0, 0, 32'h0, 0);
      total++; if (AdEL_D !== 1'b1) begin bad++; $display("[TB] FAIL oow_neg_adel got=%b want=1", AdEL_D); end
      total++; if (PC_D !== 32'h2FFC) begin bad++; $display("[TB] FAIL oow_neg_pcd got=%h want=%h", PC_D, 32'h2FFC); end
      total++; if (PC_F !== 32'h3000) begin bad++; $display("[TB] FAIL oow_neg_pc got=%h want=%h", PC_F, 32'h3000); end
   endtask

   task automatic test_reset_mid_stall;
      applyStimulus(0, 1, 0, 32'h0, 0);
      applyStimulus(1, 1, 1, 32'h5000, 1);
      total++; if (PC_F !== BASE) begin bad++; $display("[TB] FAIL rstall_pc got=%h want=%h", PC_F, BASE); end
      total++; if ({IR_D, PC_D, PC4_D} !== 96'h0) begin bad++; $display("[TB] FAIL rstall_regs got=%h/%h/%h want=0", IR_D, PC_D, PC4_D); end
      total++; if ({Valid_D, AdEL_D} !== 2'b00) begin bad++; $display("[TB] FAIL rstall_flags got=%b want=00", {Valid_D, AdEL_D}); end
   endtask

   task automatic test_random;
      logic        r, s, red, f;
      logic [31:0] rpc;
      for (int n = 0; n < 400; n++) begin
         r   = ($urandom_range(0, 49) == 0);
         s   = ($urandom_range(0, 3) == 0);
         red = ($urandom_range(0, 5) == 0);
         f   = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) rpc = $urandom;
         else rpc = BASE - 32'h100 + $urandom_range(0, 32'h1200);
         applyStimulus(r, s, red, rpc, f);
         total++; if (PC_F !== mPc) begin bad++; $display("[TB] FAIL rnd_pc n=%0d got=%h want=%h", n, PC_F, mPc); end
         total++; if (IR_D !== mIr) begin bad++; $display("[TB] FAIL rnd_ir n=%0d got=%h want=%h", n, IR_D, mIr); end
         total++; if (PC_D !== mPcD) begin bad++; $display("[TB] FAIL rnd_pcd n=%0d got=%h want=%h", n, PC_D, mPcD); end
         total++; if (PC4_D !== mPc4D) begin bad++; $display("[TB] FAIL rnd_pc4d n=%0d got=%h want=%h", n, PC4_D, mPc4D); end
         total++; if ({Valid_D, AdEL_D} !== {mValid, mAdel}) begin bad++; $display("[TB] FAIL rnd_flags n=%0d got=%b want=%b", n, {Valid_D, AdEL_D}, {mValid, mAdel}); end
         total++; if (ImAddr !== expImAddr(mPc)) begin bad++; $display("[TB] FAIL rnd_imaddr n=%0d got=%h want=%h", n, ImAddr, expImAddr(mPc)); end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) imMem[i] = $urandom;
      imMem[0] = 32'h11; imMem[1] = 32'h22; imMem[2] = 32'h33;
      Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0; Flush = 1'b0;
      mPc = 0; mIr = 0; mPcD = 0; mPc4D = 0; mValid = 0; mAdel = 0;
      test_reset;
      test_freerun;
      test_stall;
      test_redirect;
      test_redirect_stall;
      test_flush_stall;
      test_out_of_window;
      test_reset_mid_stall;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
